// File: rtl/serial_sub_16.sv
// serial_sub_16: bit-serial 16-bit unsigned subtractor, diff = A - B - bin via A + ~B + ~bin.
// Latency 16 clocks from the accepting edge; start is ignored while busy. Optional ovf output: SERIAL_SUB_OVF_EN.
module serial_sub_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] shift_q, shift_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  logic        sum_bit;
  logic        c_nxt;

  // Single full-adder stage working on the LSBs of the shifting operands
  always_comb begin
    sum_bit = opa_q[0] ^ opb_q[0] ^ c_q;
    c_nxt   = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shift_d = shift_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          opa_d   = A;
          opb_d   = ~B;
          c_d     = ~bin;
          cnt_d   = 4'd0;
        end
      end

      ST_RUN: begin
        c_d     = c_nxt;
        shift_d = {sum_bit, shift_q[15:1]};
        opa_d   = {1'b0, opa_q[15:1]};
        opb_d   = {1'b0, opb_q[15:1]};
        cnt_d   = cnt_q + 4'd1;
        // Bit 15: publish the result; carry-out inverted is the borrow
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
          diff_d  = {sum_bit, shift_q[15:1]};
          bout_d  = ~c_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = c_q ^ c_nxt;
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      opa_q   <= 16'd0;
      opb_q   <= 16'd0;
      shift_q <= 16'd0;
      c_q     <= 1'b0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 16'd0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shift_q <= shift_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

  a_done_implies_busy : assert property (@(posedge clk) disable iff (!rst) done |-> busy);
  a_done_one_cycle    : assert property (@(posedge clk) disable iff (!rst) done |=> !done);

endmodule

// File: tb/tb_serial_sub_16.sv
// Directed testbench for serial_sub_16; ovf checks are active when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub_16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one accepting edge; returns just after E0
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    a     = 16'd0;
    b     = 16'd0;
    bin   = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 16'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    int busy_cycles;
    lat = -1;
    start_op(16'd65000, 16'd340, 1'b0);
    busy_cycles = busy ? 1 : 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
    checks++; if (busy_cycles != 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 17", busy_cycles); end
    checks++; if (diff !== 16'd64660) begin errors++; $display("FAIL basic_diff: got %0d expected 64660", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b expected 0", bout); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_fall: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
  endtask

  // Prior result must stay visible until the next completion edge
  task automatic test_hold();
    int lat;
    lat = -1;
    start_op(16'd1000, 16'd2000, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin lat = k; break; end
      checks++;
      if (diff !== 16'd64660) begin errors++; $display("FAIL hold_diff cycle %0d: got %0d expected 64660", k, diff); end
    end
    checks++; if (lat != 16) begin errors++; $display("FAIL hold_latency: got %0d expected 16", lat); end
    checks++; if (diff !== 16'd64536) begin errors++; $display("FAIL neg_diff: got %0d expected 64536", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL neg_bout: got %b expected 1", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b expected 0", ovf); end
`endif
    tick();
  endtask

  task automatic test_vectors();
    logic [15:0] va   [6] = '{16'd0,     16'd32767, 16'd50, 16'd65535, 16'd5,     16'd32768};
    logic [15:0] vb   [6] = '{16'd0,     16'd65535, 16'd50, 16'd0,     16'd5,     16'd1};
    logic        vbi  [6] = '{1'b1,      1'b0,      1'b0,   1'b1,      1'b1,      1'b0};
    logic [15:0] vd   [6] = '{16'd65535, 16'd32768, 16'd0,  16'd65534, 16'd65535, 16'd32767};
    logic        vbo  [6] = '{1'b1,      1'b1,      1'b0,   1'b0,      1'b1,      1'b0};
    logic        vov  [6] = '{1'b0,      1'b1,      1'b0,   1'b0,      1'b0,      1'b1};
    for (int i = 0; i < 6; i++) begin
      int lat;
      lat = -1;
      start_op(va[i], vb[i], vbi[i]);
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (done === 1'b1) begin lat = k; break; end
      end
      checks++; if (lat != 16) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 16", i, lat); end
      checks++; if (diff !== vd[i]) begin errors++; $display("FAIL vec%0d_diff: got %0d expected %0d", i, diff, vd[i]); end
      checks++; if (bout !== vbo[i]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", i, bout, vbo[i]); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== vov[i]) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf, vov[i]); end
`else
      if (vov[i] === 1'bx) $display("note: vector %0d has no ovf expectation", i);
`endif
      tick();
    end
  endtask

  // start held high; operands are junk except in the IDLE cycle before E18
  task automatic test_back_to_back();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    a     = 16'd100;
    b     = 16'd1;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      if (k == 18) begin
        a   = 16'd40000;
        b   = 16'd50000;
        bin = 1'b1;
      end else begin
        a   = 16'(k * 1237);
        b   = 16'(k * 311 + 7);
        bin = k[0];
      end
      if (k >= 36) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = k;
          checks++; if (diff !== 16'd99) begin errors++; $display("FAIL b2b_diff1: got %0d expected 99", diff); end
          checks++; if (bout !== 1'b0) begin errors++; $display("FAIL b2b_bout1: got %b expected 0", bout); end
        end else if (d2 < 0) begin
          d2 = k;
          checks++; if (diff !== 16'd55535) begin errors++; $display("FAIL b2b_diff2: got %0d expected 55535", diff); end
          checks++; if (bout !== 1'b1) begin errors++; $display("FAIL b2b_bout2: got %b expected 1", bout); end
        end
      end
    end
    start = 1'b0;
    checks++; if (d1 != 16) begin errors++; $display("FAIL b2b_first_done: got %0d expected 16", d1); end
    checks++; if (d2 != 34) begin errors++; $display("FAIL b2b_second_done: got %0d expected 34", d2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    pulses = 0;
    lat    = -1;
    start_op(16'd65000, 16'd340, 1'b0);
    for (int k = 1; k <= 7; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (diff !== 16'd0) begin errors++; $display("FAIL midrst_diff: got %0d expected 0", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b expected 0", bout); end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    start_op(16'd1234, 16'd234, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != 16) begin errors++; $display("FAIL midrst_latency: got %0d expected 16", lat); end
    checks++; if (diff !== 16'd1000) begin errors++; $display("FAIL midrst_diff_after: got %0d expected 1000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout_after: got %b expected 0", bout); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
